// File: rtl/re_quad_level.sv
// Rotary-encoder front end: synchroniser, debounce filter, 4-edge quadrature decoder,
// detent accumulator and bounded level register. Define RE_WRAP_EN to wrap at the bounds.
module re_quad_level #(
  parameter int WIDTH            = 16,
  parameter int MIN_VAL          = 0,
  parameter int MAX_VAL          = 10000,
  parameter int RESET_VAL        = 0,
  parameter int STEP_FINE        = 1,
  parameter int STEP_COARSE      = 50,
  parameter int DEB_CYCLES       = 4,
  parameter int EDGES_PER_DETENT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             increment_select,
  input  logic             clear,
  output logic [WIDTH-1:0] ref_level,
  output logic             step_pulse,
  output logic             step_dir,
  output logic             at_limit,
  output logic             illegal_pulse
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam int ARM_W = $clog2(DEB_CYCLES + 3);

  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MIN_X   = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   FINE_X  = (WIDTH+1)'(STEP_FINE);
  localparam logic [WIDTH:0]   COARSE_X = (WIDTH+1)'(STEP_COARSE);

  localparam logic signed [3:0] ACC_TOP = 4'(EDGES_PER_DETENT);
  localparam logic signed [3:0] ACC_BOT = -ACC_TOP;

`ifdef RE_WRAP_EN
  localparam logic [WIDTH-1:0] UP_BOUND = MIN_W;
  localparam logic [WIDTH-1:0] DN_BOUND = MAX_W;
`else
  localparam logic [WIDTH-1:0] UP_BOUND = MAX_W;
  localparam logic [WIDTH-1:0] DN_BOUND = MIN_W;
`endif

  // ---------------- synchroniser and per-channel stability filter ----------------
  logic [1:0]       a_sync, b_sync;
  logic [1:0]       synced;                 // {a, b}
  logic [1:0]       filt;                   // {a_f, b_f}
  logic [CNT_W-1:0] deb_cnt [2];

  assign synced = {a_sync[1], b_sync[1]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sync <= '0;
      b_sync <= '0;
      filt   <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      a_sync <= {a_sync[0], a};
      b_sync <= {b_sync[0], b};
      for (int i = 0; i < 2; i++) begin
        if (synced[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
          filt[i]    <= synced[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------- quadrature decode ----------------
  logic             armed;
  logic [ARM_W-1:0] arm_cnt;
  logic [1:0]       prev_state;
  logic             cw_edge, ccw_edge, illegal;
  logic signed [3:0] acc, acc_next;
  logic             detent_up, detent_dn;

  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    cw_edge  = 1'b0;
    ccw_edge = 1'b0;
    illegal  = 1'b0;
    if (armed && (filt != prev_state)) begin
      if (filt == ~prev_state)               illegal  = 1'b1;
      else if (filt == cw_next(prev_state))  cw_edge  = 1'b1;
      else                                   ccw_edge = 1'b1;
    end
    acc_next = acc;
    if (cw_edge)       acc_next = acc + 4'sd1;
    else if (ccw_edge) acc_next = acc - 4'sd1;
    detent_up = cw_edge  && (acc_next == ACC_TOP);
    detent_dn = ccw_edge && (acc_next == ACC_BOT);
  end

  // ---------------- bounded level arithmetic (WIDTH+1 bits, no underflow) ----------------
  logic [WIDTH:0]   step_x, level_x, sum_x;
  logic [WIDTH-1:0] up_level, down_level;

  always_comb begin
    step_x     = increment_select ? COARSE_X : FINE_X;
    level_x    = {1'b0, ref_level};
    sum_x      = level_x + step_x;
    up_level   = sum_x[WIDTH-1:0];
    down_level = ref_level - step_x[WIDTH-1:0];
    if (sum_x > MAX_X)              up_level   = UP_BOUND;
    if (level_x < MIN_X + step_x)   down_level = DN_BOUND;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed         <= 1'b0;
      arm_cnt       <= '0;
      prev_state    <= 2'b00;
      acc           <= '0;
      ref_level     <= RESET_W;
      step_pulse    <= 1'b0;
      step_dir      <= 1'b0;
      illegal_pulse <= 1'b0;
    end else begin
      step_pulse    <= 1'b0;
      illegal_pulse <= illegal;

      // Arming snapshots the filtered state so a non-00 resting position never decodes.
      if (!armed) begin
        if (arm_cnt == ARM_W'(DEB_CYCLES + 2)) begin
          armed      <= 1'b1;
          prev_state <= filt;
        end else begin
          arm_cnt <= arm_cnt + 1'b1;
        end
      end else begin
        prev_state <= filt;
      end

      if (clear) begin
        ref_level <= RESET_W;
        acc       <= '0;
      end else if (illegal) begin
        acc <= '0;
      end else if (detent_up) begin
        ref_level  <= up_level;
        step_pulse <= 1'b1;
        step_dir   <= 1'b1;
        acc        <= '0;
      end else if (detent_dn) begin
        ref_level  <= down_level;
        step_pulse <= 1'b1;
        step_dir   <= 1'b0;
        acc        <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

  assign at_limit = (ref_level == MIN_W) || (ref_level == MAX_W);

endmodule

// File: tb/tb_re_quad_level.sv
// Self-checking bench for re_quad_level: randomized rotation against a position/accumulator
// model of the encoder, plus directed latency, glitch, illegal, clear and limit scenarios.
module tb_re_quad_level;

  localparam int WIDTH       = 16;
  localparam int MIN_VAL     = 0;
  localparam int MAX_VAL     = 10000;
  localparam int RESET_VAL   = 0;
  localparam int STEP_FINE   = 1;
  localparam int STEP_COARSE = 50;
  localparam int DEB         = 4;
  localparam int EPD         = 4;
  localparam int HOLD        = 10;

  logic             clk, reset_n, a, b, increment_select, clear;
  logic [WIDTH-1:0] ref_level;
  logic             step_pulse, step_dir, at_limit, illegal_pulse;

  re_quad_level #(
    .WIDTH(WIDTH), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .RESET_VAL(RESET_VAL),
    .STEP_FINE(STEP_FINE), .STEP_COARSE(STEP_COARSE), .DEB_CYCLES(DEB),
    .EDGES_PER_DETENT(EPD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .increment_select(increment_select),
    .clear(clear), .ref_level(ref_level), .step_pulse(step_pulse), .step_dir(step_dir),
    .at_limit(at_limit), .illegal_pulse(illegal_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Pulse monitor, sampled mid-cycle.
  int steps_seen = 0;
  int ills_seen  = 0;
  always @(negedge clk) begin
    if (step_pulse === 1'b1)    steps_seen++;
    if (illegal_pulse === 1'b1) ills_seen++;
  end

  // Reference model: encoder position on the Gray cycle, signed edge count, integer level.
  logic [1:0] pos_ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int   m_pos, m_acc, m_level, m_steps, m_ills;
  logic m_dir;

  function automatic int model_up(input int lvl, input int stp);
    if (lvl + stp > MAX_VAL) begin
`ifdef RE_WRAP_EN
      return MIN_VAL;
`else
      return MAX_VAL;
`endif
    end
    return lvl + stp;
  endfunction

  function automatic int model_down(input int lvl, input int stp);
    if (lvl - stp < MIN_VAL) begin
`ifdef RE_WRAP_EN
      return MAX_VAL;
`else
      return MIN_VAL;
`endif
    end
    return lvl - stp;
  endfunction

  task automatic model_step(input int np);
    int d, stp;
    d   = (np - m_pos + 4) % 4;
    stp = increment_select ? STEP_COARSE : STEP_FINE;
    if (d == 1)      m_acc++;
    else if (d == 3) m_acc--;
    else if (d == 2) begin m_acc = 0; m_ills++; end
    if (m_acc == EPD) begin
      m_level = model_up(m_level, stp); m_steps++; m_dir = 1'b1; m_acc = 0;
    end else if (m_acc == -EPD) begin
      m_level = model_down(m_level, stp); m_steps++; m_dir = 1'b0; m_acc = 0;
    end
    m_pos = np;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pos(input int np, input int hold);
    {a, b} = pos_ab[np];
    model_step(np);
    repeat (hold) tick;
  endtask

  task automatic rot(input bit cw, input int edges);
    for (int i = 0; i < edges; i++) drive_pos((m_pos + (cw ? 1 : 3)) % 4, HOLD);
  endtask

  task automatic do_reset(input int np);
    reset_n = 1'b0;
    clear   = 1'b0;
    {a, b}  = pos_ab[np];
    repeat (3) tick;
    reset_n = 1'b1;
    m_pos = np; m_acc = 0; m_level = RESET_VAL; m_dir = 1'b0;
    repeat (DEB + 8) tick;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    m_level = RESET_VAL; m_acc = 0;
    repeat (2) tick;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    increment_select = 1'b0;
    clear   = 1'b0;
    a = 1'b1; b = 1'b1;
    reset_n = 1'b0;
    m_steps = 0; m_ills = 0;
    repeat (3) tick;
    tests_run++;
    if (ref_level !== WIDTH'(RESET_VAL) || step_pulse !== 1'b0 || illegal_pulse !== 1'b0 || step_dir !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: level=%0d pulse=%b ill=%b dir=%b expected %0d/0/0/0",
               ref_level, step_pulse, illegal_pulse, step_dir, RESET_VAL);
    end
    reset_n = 1'b1;
    repeat (DEB + 12) tick;
    tests_run++;
    if (steps_seen !== 0 || ills_seen !== 0) begin
      tests_failed++;
      $display("FAIL reset_arm_11: steps=%0d illegal=%0d expected 0/0", steps_seen, ills_seen);
    end
    tests_run++;
    if (ref_level !== WIDTH'(RESET_VAL) || at_limit !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_level: level=%0d at_limit=%b expected %0d/1", ref_level, at_limit, RESET_VAL);
    end
    do_reset(0);
  endtask

  task automatic test_cw_latency;
    int got;
    logic [WIDTH-1:0] lvl_at_pulse;
    got = -1;
    lvl_at_pulse = '0;
    increment_select = 1'b0;
    rot(1'b1, 3);
    {a, b} = pos_ab[0];
    model_step(0);
    for (int n = 1; n <= 20 && got < 0; n++) begin
      tick;
      if (step_pulse === 1'b1) begin got = n; lvl_at_pulse = ref_level; end
    end
    tests_run++;
    if (got != DEB + 3) begin
      tests_failed++;
      $display("FAIL cw_latency: pulse after %0d clocks expected %0d", got, DEB + 3);
    end
    tests_run++;
    if (lvl_at_pulse !== WIDTH'(m_level)) begin
      tests_failed++;
      $display("FAIL cw_level_with_pulse: level=%0d expected %0d", lvl_at_pulse, m_level);
    end
    tick;
    tests_run++;
    if (step_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL cw_pulse_width: step_pulse=%b expected 0", step_pulse);
    end
    repeat (HOLD) tick;
    tests_run++;
    if (steps_seen !== m_steps || step_dir !== m_dir) begin
      tests_failed++;
      $display("FAIL cw_count_dir: steps=%0d dir=%b expected %0d/%b", steps_seen, step_dir, m_steps, m_dir);
    end
  endtask

  task automatic test_ccw_floor;
    increment_select = 1'b0;
    rot(1'b0, 2 * EPD);
    tests_run++;
    if (ref_level !== WIDTH'(m_level) || at_limit !== 1'b1) begin
      tests_failed++;
      $display("FAIL ccw_floor_level: level=%0d at_limit=%b expected %0d/1", ref_level, at_limit, m_level);
    end
    tests_run++;
    if (steps_seen !== m_steps || step_dir !== 1'b0) begin
      tests_failed++;
      $display("FAIL ccw_floor_pulses: steps=%0d dir=%b expected %0d/0", steps_seen, step_dir, m_steps);
    end
  endtask

  task automatic test_clear_detent;
    increment_select = 1'b0;
    pulse_clear;
    rot(1'b1, 2 * EPD);
    rot(1'b1, EPD - 1);
    {a, b} = pos_ab[(m_pos + 1) % 4];
    m_pos = (m_pos + 1) % 4;
    repeat (DEB + 2) tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    m_level = RESET_VAL; m_acc = 0;
    repeat (HOLD) tick;
    tests_run++;
    if (ref_level !== WIDTH'(RESET_VAL) || steps_seen !== m_steps) begin
      tests_failed++;
      $display("FAIL clear_vs_detent: level=%0d steps=%0d expected %0d/%0d",
               ref_level, steps_seen, RESET_VAL, m_steps);
    end
    // A partial detent must be forgotten by clear.
    rot(1'b1, 2);
    pulse_clear;
    rot(1'b1, 2);
    tests_run++;
    if (steps_seen !== m_steps) begin
      tests_failed++;
      $display("FAIL clear_acc: steps=%0d expected %0d", steps_seen, m_steps);
    end
    rot(1'b1, EPD - 2);
    tests_run++;
    if (steps_seen !== m_steps || ref_level !== WIDTH'(m_level)) begin
      tests_failed++;
      $display("FAIL clear_acc_detent: steps=%0d level=%0d expected %0d/%0d",
               steps_seen, ref_level, m_steps, m_level);
    end
  endtask

  task automatic test_glitch;
    {a, b} = pos_ab[m_pos] ^ 2'b10;
    repeat (DEB - 1) tick;
    {a, b} = pos_ab[m_pos];
    repeat (HOLD + 2) tick;
    tests_run++;
    if (ref_level !== WIDTH'(m_level) || steps_seen !== m_steps || ills_seen !== m_ills) begin
      tests_failed++;
      $display("FAIL glitch: level=%0d steps=%0d ill=%0d expected %0d/%0d/%0d",
               ref_level, steps_seen, ills_seen, m_level, m_steps, m_ills);
    end
  endtask

  task automatic test_illegal;
    increment_select = 1'b0;
    rot(1'b1, 2);
    drive_pos((m_pos + 2) % 4, HOLD);
    tests_run++;
    if (ills_seen !== m_ills || ref_level !== WIDTH'(m_level)) begin
      tests_failed++;
      $display("FAIL illegal_jump: ill=%0d level=%0d expected %0d/%0d", ills_seen, ref_level, m_ills, m_level);
    end
    rot(1'b1, EPD - 1);
    tests_run++;
    if (steps_seen !== m_steps) begin
      tests_failed++;
      $display("FAIL illegal_acc_cleared: steps=%0d expected %0d", steps_seen, m_steps);
    end
    rot(1'b1, 1);
    tests_run++;
    if (steps_seen !== m_steps || ref_level !== WIDTH'(m_level)) begin
      tests_failed++;
      $display("FAIL illegal_then_detent: steps=%0d level=%0d expected %0d/%0d",
               steps_seen, ref_level, m_steps, m_level);
    end
    // Illegal jump decoded in the same cycle as clear: both take effect.
    m_pos = (m_pos + 2) % 4;
    {a, b} = pos_ab[m_pos];
    repeat (DEB + 2) tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    m_ills++; m_acc = 0; m_level = RESET_VAL;
    repeat (HOLD) tick;
    tests_run++;
    if (ills_seen !== m_ills || ref_level !== WIDTH'(RESET_VAL)) begin
      tests_failed++;
      $display("FAIL illegal_with_clear: ill=%0d level=%0d expected %0d/%0d",
               ills_seen, ref_level, m_ills, RESET_VAL);
    end
  endtask

  task automatic test_limit;
    pulse_clear;
    increment_select = 1'b1;
    rot(1'b1, 199 * EPD);
    increment_select = 1'b0;
    rot(1'b1, 30 * EPD);
    tests_run++;
    if (ref_level !== WIDTH'(m_level) || at_limit !== 1'b0) begin
      tests_failed++;
      $display("FAIL limit_approach: level=%0d at_limit=%b expected %0d/0", ref_level, at_limit, m_level);
    end
    increment_select = 1'b1;
    rot(1'b1, EPD);
    tests_run++;
    if (ref_level !== WIDTH'(m_level) || at_limit !== 1'b1) begin
      tests_failed++;
      $display("FAIL limit_hit: level=%0d at_limit=%b expected %0d/1", ref_level, at_limit, m_level);
    end
    tests_run++;
    if (steps_seen !== m_steps || step_dir !== 1'b1) begin
      tests_failed++;
      $display("FAIL limit_pulse: steps=%0d dir=%b expected %0d/1", steps_seen, step_dir, m_steps);
    end
    rot(1'b1, EPD);
    tests_run++;
    if (ref_level !== WIDTH'(m_level) || steps_seen !== m_steps) begin
      tests_failed++;
      $display("FAIL limit_beyond: level=%0d steps=%0d expected %0d/%0d",
               ref_level, steps_seen, m_level, m_steps);
    end
  endtask

  task automatic test_random;
    int r;
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      increment_select = 1'($urandom_range(0, 1));
      if (r < 4)       rot(1'b1, 1);
      else if (r < 8)  rot(1'b0, 1);
      else if (r == 8) drive_pos((m_pos + 2) % 4, HOLD);
      else begin
        {a, b} = pos_ab[m_pos] ^ (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01);
        repeat ($urandom_range(1, DEB - 1)) tick;
        {a, b} = pos_ab[m_pos];
        repeat (HOLD) tick;
      end
      tests_run++;
      if (ref_level !== WIDTH'(m_level) || steps_seen !== m_steps || ills_seen !== m_ills) begin
        tests_failed++;
        $display("FAIL random_%0d: level=%0d steps=%0d ill=%0d expected %0d/%0d/%0d",
                 it, ref_level, steps_seen, ills_seen, m_level, m_steps, m_ills);
      end
    end
  endtask

  task automatic test_reset_midrot;
    increment_select = 1'b0;
    pulse_clear;
    rot(1'b1, EPD + 1);
    do_reset(m_pos);
    tests_run++;
    if (steps_seen !== m_steps || ills_seen !== m_ills || ref_level !== WIDTH'(RESET_VAL) || step_dir !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrot_rearm: steps=%0d ill=%0d level=%0d dir=%b expected %0d/%0d/%0d/0",
               steps_seen, ills_seen, ref_level, step_dir, m_steps, m_ills, RESET_VAL);
    end
    rot(1'b1, EPD);
    tests_run++;
    if (steps_seen !== m_steps || ref_level !== WIDTH'(m_level)) begin
      tests_failed++;
      $display("FAIL midrot_detent: steps=%0d level=%0d expected %0d/%0d",
               steps_seen, ref_level, m_steps, m_level);
    end
  endtask

  initial begin
    test_reset;
    test_cw_latency;
    test_ccw_floor;
    test_clear_detent;
    test_glitch;
    test_illegal;
    test_limit;
    test_random;
    test_reset_midrot;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
